// File: rtl/load_align_if.sv
// Handshake bundle between the X stage, DMEM and writeback for load_align_unit.
// The master modport is the environment side; the slave modport is the unit.
interface load_align_if #(
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
);
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       inst_X;
  logic [ADDR_W-1:0] addr_X;
  logic              dmem_re;
  logic [ADDR_W-1:0] dmem_addr;
  logic              dmem_rvalid;
  logic [31:0]       dmem_rdata;
  logic              load_valid;
  logic [31:0]       load_data;
  logic [RD_W-1:0]   load_rd;
  logic              load_misaligned;

  modport master (
    output req_valid, inst_X, addr_X, dmem_rvalid, dmem_rdata,
    input  req_ready, dmem_re, dmem_addr, load_valid, load_data, load_rd, load_misaligned
  );

  modport slave (
    input  req_valid, inst_X, addr_X, dmem_rvalid, dmem_rdata,
    output req_ready, dmem_re, dmem_addr, load_valid, load_data, load_rd, load_misaligned
  );
endinterface

// File: rtl/load_align_unit.sv
// Load alignment unit: issues word-aligned DMEM reads, then extracts and extends the result.
// Define LOAD_SPLIT_MISALIGNED_EN to service word-crossing loads with a second read.
module load_align_unit #(
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  load_align_if.slave  bus
);
  // state    | meaning
  // S_IDLE   | ready for a new load
  // S_ISSUE0 | read strobe for the first word
  // S_WAIT0  | waiting for first word
  // S_ISSUE1 | read strobe for the following word (split loads only)
  // S_WAIT1  | waiting for second word (split loads only)
  // S_RESP   | one-cycle result pulse
  localparam logic [6:0] OP_LOAD = 7'b0000011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE0,
    S_WAIT0,
`ifdef LOAD_SPLIT_MISALIGNED_EN
    S_ISSUE1,
    S_WAIT1,
`endif
    S_RESP
  } state_t;

  state_t            r_state;
  logic              r_req_ready;
  logic              r_dmem_re;
  logic [ADDR_W-1:0] r_dmem_addr;
  logic              r_load_valid;
  logic [31:0]       r_load_data;
  logic [RD_W-1:0]   r_load_rd;
  logic              r_load_mis;
  logic [2:0]        r_f3;
  logic [RD_W-1:0]   r_rd;
  logic [1:0]        r_off;
`ifdef LOAD_SPLIT_MISALIGNED_EN
  logic              r_cross;
  logic [31:0]       r_w0;
  logic [ADDR_W-1:0] r_word_addr;
`endif

  logic [2:0]        w_f3;
  logic [1:0]        w_off;
  logic              w_is_load;
  logic              w_legal;
  logic              w_cross;
  logic              w_reject;
  logic [ADDR_W-1:0] w_word_addr;
  logic              w_unused;

  assign w_f3        = bus.inst_X[14:12];
  assign w_off       = bus.addr_X[1:0];
  assign w_is_load   = (bus.inst_X[6:0] == OP_LOAD);
  assign w_word_addr = {bus.addr_X[ADDR_W-1:2], 2'b00};
  assign w_legal     = (w_f3 == 3'b000) || (w_f3 == 3'b001) || (w_f3 == 3'b010) ||
                       (w_f3 == 3'b100) || (w_f3 == 3'b101);
  assign w_cross     = (((w_f3 == 3'b001) || (w_f3 == 3'b101)) && (w_off == 2'd3)) ||
                       ((w_f3 == 3'b010) && (w_off != 2'd0));
  assign w_unused    = ^bus.inst_X[31:15];

`ifdef LOAD_SPLIT_MISALIGNED_EN
  assign w_reject = ~w_legal;
`else
  assign w_reject = ~w_legal | w_cross;
`endif

  // {w1,w0} shifted by the byte offset lines the addressed data up at bit 0 for every width.
  function automatic logic [31:0] f_extract(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w0, input logic [31:0] w1);
    logic [31:0] sh;
    sh = 32'({w1, w0} >> {off, 3'b000});
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b010:  return sh;
      3'b100:  return {24'h0, sh[7:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_dmem_re    <= 1'b0;
      r_dmem_addr  <= '0;
      r_load_valid <= 1'b0;
      r_load_data  <= 32'h0;
      r_load_rd    <= '0;
      r_load_mis   <= 1'b0;
      r_f3         <= 3'b000;
      r_rd         <= '0;
      r_off        <= 2'b00;
`ifdef LOAD_SPLIT_MISALIGNED_EN
      r_cross      <= 1'b0;
      r_w0         <= 32'h0;
      r_word_addr  <= '0;
`endif
    end else begin
      r_dmem_re    <= 1'b0;
      r_dmem_addr  <= '0;
      r_load_valid <= 1'b0;
      r_load_data  <= 32'h0;
      r_load_rd    <= '0;
      r_load_mis   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid && w_is_load) begin
            r_f3        <= w_f3;
            r_rd        <= RD_W'(bus.inst_X[11:7]);
            r_off       <= w_off;
            r_req_ready <= 1'b0;
`ifdef LOAD_SPLIT_MISALIGNED_EN
            r_cross     <= w_cross;
            r_word_addr <= w_word_addr;
`endif
            if (w_reject) begin
              r_state      <= S_RESP;
              r_load_valid <= 1'b1;
              r_load_mis   <= 1'b1;
              r_load_rd    <= RD_W'(bus.inst_X[11:7]);
            end else begin
              r_state     <= S_ISSUE0;
              r_dmem_re   <= 1'b1;
              r_dmem_addr <= w_word_addr;
            end
          end
        end
        S_ISSUE0: r_state <= S_WAIT0;
        S_WAIT0: begin
          if (bus.dmem_rvalid) begin
`ifdef LOAD_SPLIT_MISALIGNED_EN
            if (r_cross) begin
              r_w0        <= bus.dmem_rdata;
              r_state     <= S_ISSUE1;
              r_dmem_re   <= 1'b1;
              r_dmem_addr <= r_word_addr + ADDR_W'(4);
            end else begin
              r_state      <= S_RESP;
              r_load_valid <= 1'b1;
              r_load_data  <= f_extract(r_f3, r_off, bus.dmem_rdata, 32'h0);
              r_load_rd    <= r_rd;
            end
`else
            r_state      <= S_RESP;
            r_load_valid <= 1'b1;
            r_load_data  <= f_extract(r_f3, r_off, bus.dmem_rdata, 32'h0);
            r_load_rd    <= r_rd;
`endif
          end
        end
`ifdef LOAD_SPLIT_MISALIGNED_EN
        S_ISSUE1: r_state <= S_WAIT1;
        S_WAIT1: begin
          if (bus.dmem_rvalid) begin
            r_state      <= S_RESP;
            r_load_valid <= 1'b1;
            r_load_data  <= f_extract(r_f3, r_off, r_w0, bus.dmem_rdata);
            r_load_rd    <= r_rd;
          end
        end
`endif
        S_RESP: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready       = r_req_ready;
  assign bus.dmem_re         = r_dmem_re;
  assign bus.dmem_addr       = r_dmem_addr;
  assign bus.load_valid      = r_load_valid;
  assign bus.load_data       = r_load_data;
  assign bus.load_rd         = r_load_rd;
  assign bus.load_misaligned = r_load_mis;
endmodule

// File: tb/tb_load_align_unit.sv
// Directed self-checking bench for load_align_unit; follows LOAD_SPLIT_MISALIGNED_EN if defined.
module tb_load_align_unit;
  localparam logic [6:0]  OP_LOAD = 7'b0000011;
  localparam logic [31:0] JUNK    = 32'h5A5A5A5A;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  load_align_if #(.ADDR_W(32), .RD_W(5)) bus ();

  load_align_unit #(.ADDR_W(32), .RD_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
    return {17'h0, f3, rd, op};
  endfunction

  // Presents one request, plays DMEM with 'lat' cycles from strobe to rvalid, checks every cycle.
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] addr, input int n_acc,
                          input logic [31:0] a0, input logic [31:0] d0,
                          input logic [31:0] a1, input logic [31:0] d1, input int lat,
                          input logic [31:0] exp_d, input logic exp_mis);
    chk({tag, "/ready_in"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.inst_X    = mk_inst(f3, rd, OP_LOAD);
    bus.addr_X    = addr;
    tick();
    bus.req_valid = 1'b0;
    bus.inst_X    = 32'h0;
    bus.addr_X    = 32'h0;
    for (int k = 0; k < n_acc; k++) begin
      chk({tag, "/re"},    32'(bus.dmem_re),   32'd1);
      chk({tag, "/addr"},  bus.dmem_addr,      (k == 0) ? a0 : a1);
      chk({tag, "/busy"},  32'(bus.req_ready), 32'd0);
      tick();
      for (int i = 1; i < lat; i++) begin
        chk({tag, "/wait"}, 32'({bus.dmem_re, bus.load_valid, bus.req_ready}), 32'd0);
        tick();
      end
      bus.dmem_rvalid = 1'b1;
      bus.dmem_rdata  = (k == 0) ? d0 : d1;
      tick();
      bus.dmem_rvalid = 1'b0;
      bus.dmem_rdata  = JUNK;
    end
    chk({tag, "/valid"}, 32'(bus.load_valid),      32'd1);
    chk({tag, "/data"},  bus.load_data,            exp_d);
    chk({tag, "/rd"},    32'(bus.load_rd),         32'(rd));
    chk({tag, "/mis"},   32'(bus.load_misaligned), 32'(exp_mis));
    chk({tag, "/re_r"},  32'(bus.dmem_re),         32'd0);
    tick();
    chk({tag, "/done"},  32'({bus.load_valid, bus.load_misaligned, bus.req_ready}), 32'd1);
    chk({tag, "/clr"},   bus.load_data,            32'h0);
  endtask

  initial begin
    n_cmp           = 0;
    n_err           = 0;
    rst_n           = 1'b0;
    bus.req_valid   = 1'b0;
    bus.inst_X      = 32'h0;
    bus.addr_X      = 32'h0;
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata  = JUNK;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst/ready", 32'(bus.req_ready), 32'd1);
    chk("rst/outs",  32'({bus.dmem_re, bus.load_valid, bus.load_misaligned}), 32'd0);
    chk("rst/data",  bus.load_data, 32'h0);

    // Reset while waiting on the first read, then stray rvalid in IDLE
    bus.req_valid = 1'b1;
    bus.inst_X    = mk_inst(3'b010, 5'd9, OP_LOAD);
    bus.addr_X    = 32'h200;
    tick();
    bus.req_valid = 1'b0;
    chk("mid/re", 32'(bus.dmem_re), 32'd1);
    tick();
    chk("mid/wait_busy", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid/rst_ready", 32'(bus.req_ready), 32'd1);
    chk("mid/rst_outs",  32'({bus.dmem_re, bus.load_valid}), 32'd0);
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h12345678;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stray/quiet", 32'({bus.load_valid, bus.dmem_re, bus.req_ready}), 32'd1);
    end
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata  = JUNK;

    run_load("lw_aligned", 3'b010, 5'd5,  32'h100, 1, 32'h100, 32'hDEADBEEF, 32'h0, 32'h0, 1,
             32'hDEADBEEF, 1'b0);
    run_load("lb_off3",    3'b000, 5'd7,  32'h103, 1, 32'h100, 32'h80112233, 32'h0, 32'h0, 1,
             32'hFFFFFF80, 1'b0);
    run_load("lbu_off3",   3'b100, 5'd8,  32'h103, 1, 32'h100, 32'h80112233, 32'h0, 32'h0, 1,
             32'h00000080, 1'b0);
    run_load("lhu_off2",   3'b101, 5'd10, 32'h102, 1, 32'h100, 32'h80112233, 32'h0, 32'h0, 1,
             32'h00008011, 1'b0);
    run_load("lh_off1",    3'b001, 5'd11, 32'h101, 1, 32'h100, 32'h12F0A055, 32'h0, 32'h0, 3,
             32'hFFFFF0A0, 1'b0);
    run_load("lb_off1",    3'b000, 5'd12, 32'h341, 1, 32'h340, 32'h00007F00, 32'h0, 32'h0, 2,
             32'h0000007F, 1'b0);

`ifdef LOAD_SPLIT_MISALIGNED_EN
    run_load("lw_cross",   3'b010, 5'd13, 32'h0FF, 2, 32'h0FC, 32'hAABBCCDD, 32'h100, 32'h11223344, 1,
             32'h223344AA, 1'b0);
    run_load("lh_wrap",    3'b001, 5'd14, 32'hFFFFFFFF, 2, 32'hFFFFFFFC, 32'h7F000000,
             32'h00000000, 32'h000000FF, 2, 32'hFFFFFF7F, 1'b0);
`else
    run_load("lw_cross",   3'b010, 5'd13, 32'h0FF, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1,
             32'h0, 1'b1);
    run_load("lh_wrap",    3'b001, 5'd14, 32'hFFFFFFFF, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1,
             32'h0, 1'b1);
`endif

    // Store opcode is not a load: nothing happens
    bus.req_valid = 1'b1;
    bus.inst_X    = mk_inst(3'b010, 5'd3, 7'h23);
    bus.addr_X    = 32'h100;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("nonload/idle", 32'({bus.dmem_re, bus.load_valid, bus.req_ready}), 32'd1);
    end
    bus.req_valid = 1'b0;

    run_load("f3_011", 3'b011, 5'd15, 32'h100, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 32'h0, 1'b1);
    run_load("f3_111", 3'b111, 5'd16, 32'h104, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 32'h0, 1'b1);
    run_load("lw_b2b", 3'b010, 5'd31, 32'h10, 1, 32'h10, 32'h0BADF00D, 32'h0, 32'h0, 1,
             32'h0BADF00D, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
